alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, request FIFO depth; power of two, minimum 2.
REQ-002 Port: clk  in  1  rising-edge clock; the only clock.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  in  1  upstream request valid.
REQ-005 Port: in_ready  out  1  queue can accept a request.
REQ-006 Port: in_num1  in  8  operand A.
REQ-007 Port: in_num2  in  32  operand B.
REQ-008 Port: in_op  in  3  ALU opcode.
REQ-009 Port: alu_num1  out  8  operand A to the downstream ALU.
REQ-010 Port: alu_num2  out  32  operand B to the downstream ALU.
REQ-011 Port: alu_op  out  3  opcode to the downstream ALU.
REQ-012 Port: alu_ans  in  32  combinational ALU result for the current alu_* inputs.
REQ-013 Port: out_valid  out  1  result register holds a valid result.
REQ-014 Port: out_ready  in  1  consumer accepts the result.
REQ-015 Port: out_ans  out  32  registered result.
REQ-016 Port: out_op  out  3  opcode that produced out_ans.
REQ-017 Port: out_err  out  1  result came from an illegal opcode (3'b110 or 3'b111).
REQ-018 Port: count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-019 in_ready SHALL equal (count != DEPTH).
- Combinational from registered state only.
- in_ready SHALL NOT depend on in_valid or out_ready.
REQ-020 A push SHALL occur on a rising edge with in_valid && in_ready.
- Writes {in_num1, in_num2, in_op} at the write pointer.
- The write pointer wraps modulo DEPTH.
REQ-021 When count != 0, alu_num1, alu_num2 and alu_op SHALL present the head entry; when count == 0, all three SHALL be 0.
REQ-022 Issue SHALL occur on an edge where count != 0 && (!out_valid || out_ready). On issue:
- out_ans <= alu_ans, or 0 if the head op >= 3'b110;
- out_op <= head op;
- out_err <= (head op >= 3'b110);
- out_valid <= 1;
- the read pointer advances and wraps modulo DEPTH.
REQ-023 On an edge with out_valid && out_ready and no issue, out_valid SHALL go to 0; out_ans, out_op and out_err hold their values.
REQ-024 While out_valid && !out_ready, out_ans, out_op and out_err SHALL remain stable.
REQ-025 When a push and an issue occur on the same edge, count SHALL remain unchanged; otherwise count increments on a push and decrements on an issue.
REQ-026 A request SHALL NOT bypass the FIFO.
- A push accepted at edge N into an empty queue issues no earlier than edge N+1.
- out_valid rises after edge N+1.
REQ-027 With out_ready held at 1 and in_valid held at 1, the queue SHALL sustain one result per cycle; results appear in acceptance order.
REQ-028 A push attempted while count == DEPTH SHALL be ignored, even if an issue occurs on the same edge.

Reset
REQ-029 On a rising edge with rst_n == 0, the block SHALL set:
- count = 0;
- read and write pointers = 0;
- out_valid = 0, out_ans = 0, out_op = 0, out_err = 0.
FIFO storage is not reset.
REQ-030 Reset SHALL override a push or issue on the same edge.
- Queued entries and any pending result are discarded.
- in_ready = 1 after the reset edge.

Verification
REQ-031 The bench SHALL instantiate the team ALU on the alu_* and alu_ans ports and cover the following scenarios.
- Single request: push {num1=8'h02, num2=32'h1, op=000} at edge N, out_ready=1 -> out_valid=1 after N+1, out_ans=32'h3, out_op=000, out_err=0; count 1 then 0.
- Fill and stall: out_ready=0, six back-to-back requests -> first request goes to the result register; next four reach count=4; in_ready=0; sixth holds until out_ready=1, then is accepted.
- Backpressure: out_valid=1, out_ready=0 for 10 cycles -> out_ans, out_op and out_err unchanged every cycle.
- Streaming: out_ready=1, eight requests with op cycling 000..101, num2=32'h1 -> eight results on eight consecutive cycles, in order, count <= 1.
- Illegal op: push op=3'b111 -> out_err=1, out_ans=0, out_op=111.
- Mid-operation reset: count=3 and out_valid=1, rst_n=0 for one edge -> count=0, out_valid=0, in_ready=1; none of the prior entries ever appear on out_*.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: request FIFO in front of a combinational ALU, with a
// registered result stage and a valid/ready handshake on both sides.
// The head entry drives the external ALU. Its answer is captured into the
// result register when the head issues.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_num1,
  input  logic [31:0]                in_num2,
  input  logic [2:0]                 in_op,
  output logic [7:0]                 alu_num1,
  output logic [31:0]                alu_num2,
  output logic [2:0]                 alu_op,
  input  logic [31:0]                alu_ans,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_ans,
  output logic [2:0]                 out_op,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [7:0]  num1;
    logic [31:0] num2;
    logic [2:0]  op;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, issue, empty, illegal;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign issue    = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];
  // Opcodes 110 and 111 are illegal: flagged in out_err, answer forced to 0.
  assign illegal  = head.op[2] & head.op[1];

  // The ALU sees zeros while the queue is empty, so stale storage never leaks out.
  always_comb begin
    alu_num1 = '0;
    alu_num2 = '0;
    alu_op   = '0;
    if (!empty) begin
      alu_num1 = head.num1;
      alu_num2 = head.num2;
      alu_op   = head.op;
    end
  end

  // Storage write. The data is not reset, and a push on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[wr_ptr] <= '{num1: in_num1, num2: in_num2, op: in_op};
  end

  // Pointers and occupancy. Both pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result register. It loads on issue and only drops valid when it is drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ans   <= '0;
      out_op    <= '0;
      out_err   <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_ans   <= illegal ? 32'h0 : alu_ans;
      out_op    <= head.op;
      out_err   <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a small behavioural ALU on the alu_* ports.
module tb_alu_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_num1;
  logic [31:0] in_num2;
  logic [2:0]  in_op;
  logic [7:0]  alu_num1;
  logic [31:0] alu_num2;
  logic [2:0]  alu_op;
  logic [31:0] alu_ans;
  logic        out_valid, out_ready;
  logic [31:0] out_ans;
  logic [2:0]  out_op;
  logic        out_err;
  logic [2:0]  count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num1(in_num1), .in_num2(in_num2), .in_op(in_op),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
    .alu_ans(alu_ans),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ans(out_ans), .out_op(out_op), .out_err(out_err),
    .count(count)
  );

  // Team ALU: add, sub, and, or, xor, shift-left. Illegal ops return garbage.
  always_comb begin
    alu_ans = 32'hDEAD_BEEF;
    case (alu_op)
      3'd0: alu_ans = {24'h0, alu_num1} + alu_num2;
      3'd1: alu_ans = {24'h0, alu_num1} - alu_num2;
      3'd2: alu_ans = {24'h0, alu_num1} & alu_num2;
      3'd3: alu_ans = {24'h0, alu_num1} | alu_num2;
      3'd4: alu_ans = {24'h0, alu_num1} ^ alu_num2;
      3'd5: alu_ans = alu_num2 << alu_num1[4:0];
      default: alu_ans = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic        iv;
    logic [7:0]  n1;
    logic [31:0] n2;
    logic [2:0]  op;
    logic        ordy;
    logic        ov;
    logic [31:0] ans;
    logic [2:0]  oop;
    logic        err;
    logic [2:0]  cnt;
    logic        irdy;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] n1, input logic [31:0] n2,
                       input logic [2:0] op);
    in_valid = iv;
    in_num1  = n1;
    in_num2  = n2;
    in_op    = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0] hold_ans;
  logic [2:0]  hold_op;
  logic        hold_err;
  int          seen_old;

  initial begin
    // Streaming: op cycling 000..101, num2=1; expected results computed by hand.
    tbl[0] = '{1'b1, 8'h05, 32'h1, 3'd0, 1'b1, 1'b0, 32'h0,  3'd0, 1'b0, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 8'h05, 32'h1, 3'd1, 1'b1, 1'b1, 32'h6,  3'd0, 1'b0, 3'd1, 1'b1};
    tbl[2] = '{1'b1, 8'h0F, 32'h1, 3'd2, 1'b1, 1'b1, 32'h4,  3'd1, 1'b0, 3'd1, 1'b1};
    tbl[3] = '{1'b1, 8'h0F, 32'h1, 3'd3, 1'b1, 1'b1, 32'h1,  3'd2, 1'b0, 3'd1, 1'b1};
    tbl[4] = '{1'b1, 8'h0F, 32'h1, 3'd4, 1'b1, 1'b1, 32'hF,  3'd3, 1'b0, 3'd1, 1'b1};
    tbl[5] = '{1'b1, 8'h04, 32'h1, 3'd5, 1'b1, 1'b1, 32'hE,  3'd4, 1'b0, 3'd1, 1'b1};
    tbl[6] = '{1'b1, 8'h03, 32'h1, 3'd0, 1'b1, 1'b1, 32'h10, 3'd5, 1'b0, 3'd1, 1'b1};
    tbl[7] = '{1'b1, 8'h03, 32'h1, 3'd1, 1'b1, 1'b1, 32'h4,  3'd0, 1'b0, 3'd1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 32'h0, 3'd0, 1'b1, 1'b1, 32'h2,  3'd1, 1'b0, 3'd0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 32'h0, 3'd0, 1'b1, 1'b0, 32'h2,  3'd1, 1'b0, 3'd0, 1'b1};

    drive(1'b0, 8'h0, 32'h0, 3'd0);
    out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ans", out_ans, 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_alu_op", {24'h0, alu_num1} | alu_num2 | 32'(alu_op), 32'd0);

    // Streaming table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].n1, tbl[i].n2, tbl[i].op);
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("stream%0d_ans", i), out_ans, tbl[i].ans);
      chk($sformatf("stream%0d_op", i), 32'(out_op), 32'(tbl[i].oop));
      chk($sformatf("stream%0d_err", i), 32'(out_err), 32'(tbl[i].err));
      chk($sformatf("stream%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].irdy));
    end

    // Single request with no bypass: 2 + 1 = 3
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'h02, 32'h1, 3'd0);
    step();
    drive(1'b0, 8'h0, 32'h0, 3'd0);
    chk("single_count1", 32'(count), 32'd1);
    chk("single_nobypass", 32'(out_valid), 32'd0);
    chk("single_alu_num1", 32'(alu_num1), 32'h2);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_ans", out_ans, 32'h3);
    chk("single_op", 32'(out_op), 32'd0);
    chk("single_err", 32'(out_err), 32'd0);
    chk("single_count0", 32'(count), 32'd0);

    // Fill and stall: six adds num1=10..15, num2=1 (answers 11..16), out_ready=0
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 32'h1, 3'd0);
      step();
    end
    chk("fill_count4", 32'(count), 32'd4);
    chk("fill_in_ready0", 32'(in_ready), 32'd0);
    chk("fill_first_ans", out_ans, 32'h11);
    drive(1'b1, 8'h15, 32'h1, 3'd0);
    step();
    chk("fill_sixth_held", 32'(count), 32'd4);
    out_ready = 1'b1;
    step();  // issue B; F refused since the queue was full at this edge
    chk("fill_full_issue_count", 32'(count), 32'd3);
    chk("fill_ans_b", out_ans, 32'h12);
    step();  // F accepted, C issued
    drive(1'b0, 8'h0, 32'h0, 3'd0);
    chk("fill_sixth_accepted", 32'(count), 32'd3);
    chk("fill_ans_c", out_ans, 32'h13);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fill_drain%0d", i), out_ans, 32'h14 + 32'(i));
      chk($sformatf("fill_drain%0d_count", i), 32'(count), 32'(2 - i));
    end
    step();
    chk("fill_drained_valid", 32'(out_valid), 32'd0);

    // Backpressure: F0 | 0F = FF held for 10 cycles
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'hF0, 32'h0F, 3'd3);
    step();
    drive(1'b1, 8'h01, 32'h1, 3'd0);
    step();
    drive(1'b0, 8'h0, 32'h0, 3'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ans", out_ans, 32'hFF);
    hold_ans = out_ans;
    hold_op  = out_op;
    hold_err = out_err;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp%0d_stable", i),
          {out_ans[31:5], out_valid, out_err, out_op} ^ {hold_ans[31:5], 1'b1, hold_err, hold_op},
          32'd0);
      chk($sformatf("bp%0d_ans_low", i), 32'(out_ans[4:0]), 32'(hold_ans[4:0]));
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_ans", out_ans, 32'h2);

    // Illegal ops: 110 and 111 flagged, answer forced to 0
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'h33, 32'h44, 3'd7);
    step();
    drive(1'b1, 8'h55, 32'h66, 3'd6);
    step();
    chk("ill7_err", 32'(out_err), 32'd1);
    chk("ill7_ans", out_ans, 32'd0);
    chk("ill7_op", 32'(out_op), 32'd7);
    drive(1'b1, 8'h07, 32'h1, 3'd0);
    step();
    drive(1'b0, 8'h0, 32'h0, 3'd0);
    chk("ill6_err", 32'(out_err), 32'd1);
    chk("ill6_op", 32'(out_op), 32'd6);
    chk("ill6_ans", out_ans, 32'd0);
    step();
    chk("ill_after_err", 32'(out_err), 32'd0);
    chk("ill_after_ans", out_ans, 32'h8);

    // Mid-operation reset: answers 0xA1..0xA4 must never appear
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 32'h1, 3'd0);
      step();
    end
    chk("mr_pre_count", 32'(count), 32'd3);
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b0, 8'h0, 32'h0, 3'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    seen_old = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) seen_old++;
    end
    chk("mr_no_stale", 32'(seen_old), 32'd0);
    drive(1'b1, 8'h20, 32'h3, 3'd2);
    step();
    drive(1'b0, 8'h0, 32'h0, 3'd0);
    step();
    chk("mr_fresh_valid", 32'(out_valid), 32'd1);
    chk("mr_fresh_ans", out_ans, 32'h0);
    chk("mr_fresh_op", 32'(out_op), 32'd2);
    step();
    chk("mr_final_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
